// File: rtl/alu_frame_interface.sv
// Purpose: parses SYNC/opcode/A/B frames from an RX FIFO, drives an ALU, returns result and status bytes to a TX FIFO.
// Latency: EXEC follows the last operand pop by one cycle; the result is written one cycle later and the status one cycle after that.
// Backpressure: RX pops only while the FIFO is non-empty; TX writes hold, with the write strobe low, while the TX FIFO is full.
module alu_frame_interface #(
    parameter int         NB_DATA        = 8,
    parameter int         NB_OPCODE      = 6,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_data_to_read,
    input  logic                 i_fifo_rx_empty,
    input  logic                 i_fifo_tx_full,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_alu_zero,
    input  logic                 i_alu_carry,
    output logic                 o_fifo_rx_read,
    output logic                 o_fifo_tx_write,
    output logic [NB_DATA-1:0]   o_data_to_write,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    output logic [NB_DATA-1:0]   o_alu_op_A,
    output logic [NB_DATA-1:0]   o_alu_op_B,
    output logic                 o_alu_valid,
    output logic                 o_busy,
    output logic [NB_DATA-1:0]   o_timeout_cnt
);

    localparam int                    NB_TIMEOUT   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [NB_DATA-1:0]    SYNC_WORD    = NB_DATA'(SYNC_BYTE);
    // The abort fires on the empty cycle that would bring the count to TIMEOUT_CYCLES.
    localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        OPCODE  = 3'd1,
        OPA     = 3'd2,
        OPB     = 3'd3,
        EXEC    = 3'd4,
        TX_RES  = 3'd5,
        TX_STAT = 3'd6
    } state_t;

    state_t                 state_q,  state_d;
    logic [NB_OPCODE-1:0]   opcode_q, opcode_d;
    logic [NB_DATA-1:0]     op_a_q,   op_a_d;
    logic [NB_DATA-1:0]     op_b_q,   op_b_d;
    logic [NB_DATA-1:0]     res_q,    res_d;
    logic                   zero_q,   zero_d;
    logic                   carry_q,  carry_d;
    logic                   sticky_q, sticky_d;
    logic [NB_TIMEOUT-1:0]  cnt_q,    cnt_d;
    logic [NB_DATA-1:0]     tcnt_q,   tcnt_d;

    logic                   rx_state;
    logic                   pop;
    logic                   tx_wr;
    logic [NB_DATA-1:0]     status_byte;

    // Next-state, operand capture, inter-byte timeout and strobes for the frame parser.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        res_d       = res_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;
        tcnt_d      = tcnt_q;

        rx_state    = (state_q == OPCODE) || (state_q == OPA) || (state_q == OPB);
        // Strobes are gated by reset so nothing is consumed or emitted in a reset cycle.
        pop         = !i_reset && !i_fifo_rx_empty && ((state_q == HUNT) || rx_state);
        tx_wr       = !i_reset && !i_fifo_tx_full && ((state_q == TX_RES) || (state_q == TX_STAT));
        status_byte = NB_DATA'({sticky_q, carry_q, zero_q});

        // Inter-byte watchdog: a pop always wins over an expiring count.
        if (rx_state) begin
            if (pop) begin
                cnt_d = '0;
            end else if (cnt_q >= TIMEOUT_LAST) begin
                state_d  = HUNT;
                cnt_d    = '0;
                sticky_d = 1'b1;
                if (tcnt_q != '1) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            HUNT: begin
                if (pop && (i_data_to_read == SYNC_WORD)) begin
                    state_d = OPCODE;
                    cnt_d   = '0;
                end
            end
            OPCODE: begin
                if (pop) begin
                    opcode_d = i_data_to_read[NB_OPCODE-1:0];
                    state_d  = OPA;
                end
            end
            OPA: begin
                if (pop) begin
                    op_a_d  = i_data_to_read;
                    state_d = OPB;
                end
            end
            OPB: begin
                if (pop) begin
                    op_b_d  = i_data_to_read;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_d   = i_alu_result;
                zero_d  = i_alu_zero;
                carry_d = i_alu_carry;
                state_d = TX_RES;
            end
            TX_RES: begin
                if (tx_wr) begin
                    state_d = TX_STAT;
                end
            end
            TX_STAT: begin
                if (tx_wr) begin
                    sticky_d = 1'b0;
                    state_d  = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        o_fifo_rx_read  = pop;
        o_fifo_tx_write = tx_wr;
        o_data_to_write = !tx_wr ? '0 : ((state_q == TX_RES) ? res_q : status_byte);
        o_alu_valid     = !i_reset && (state_q == EXEC);
        o_busy          = !i_reset && (state_q != HUNT);
    end

    // State and datapath registers with synchronous reset to an empty, idle frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= HUNT;
            opcode_q <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
        end
    end

    assign o_alu_opcode  = opcode_q;
    assign o_alu_op_A    = op_a_q;
    assign o_alu_op_B    = op_b_q;
    assign o_timeout_cnt = tcnt_q;

endmodule

// File: tb/tb_alu_frame_interface.sv
// Bench for alu_frame_interface: byte-level frame model with expectation queues, checked on every cycle.
// Stimulus bytes are offered one at a time with a chosen number of empty cycles before each.
// TX backpressure is either directed or randomised.
module tb_alu_frame_interface;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       tx_full;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic       alu_carry;
    logic       rx_read;
    logic       tx_write;
    logic [7:0] tx_data;
    logic [5:0] alu_opc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_valid;
    logic       busy;
    logic [7:0] tcnt;

    alu_frame_interface #(
        .NB_DATA(8), .NB_OPCODE(6), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_data_to_read(rx_data),
        .i_fifo_rx_empty(rx_empty), .i_fifo_tx_full(tx_full),
        .i_alu_result(alu_res), .i_alu_zero(alu_zero), .i_alu_carry(alu_carry),
        .o_fifo_rx_read(rx_read), .o_fifo_tx_write(tx_write), .o_data_to_write(tx_data),
        .o_alu_opcode(alu_opc), .o_alu_op_A(alu_a), .o_alu_op_B(alu_b),
        .o_alu_valid(alu_valid), .o_busy(busy), .o_timeout_cnt(tcnt)
    );

    always #5 clk = ~clk;

    // External ALU: MIPS-style function codes; carry is bit 8 of the 9-bit result.
    function automatic logic [8:0] alu_fn(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            6'h20:   return {1'b0, a} + {1'b0, b};
            6'h22:   return {1'b0, a} - {1'b0, b};
            6'h24:   return {1'b0, a & b};
            6'h25:   return {1'b0, a | b};
            6'h26:   return {1'b0, a ^ b};
            6'h27:   return {1'b0, ~(a | b)};
            default: return {1'b0, a};
        endcase
    endfunction

    logic [8:0] alu_full;
    assign alu_full  = alu_fn(alu_opc, alu_a, alu_b);
    assign alu_res   = alu_full[7:0];
    assign alu_carry = alu_full[8];
    assign alu_zero  = (alu_full[7:0] == 8'h00);

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: byte-stream frame parser ----------------
    logic [7:0]  exp_tx[$];
    logic [21:0] exp_op[$];
    int          m_st = 0;
    logic [5:0]  m_opc;
    logic [7:0]  m_a;
    logic        m_sticky = 1'b0;
    int          m_tcnt = 0;

    // gap = empty cycles before this byte, counted from the cycle after the previous pop.
    task automatic model_byte(input logic [7:0] b, input int gap);
        logic [8:0] r;
        if (m_st != 0 && gap >= TO) begin
            m_st     = 0;
            m_sticky = 1'b1;
            if (m_tcnt < 255) m_tcnt++;
        end
        case (m_st)
            0: if (b == 8'hA5) m_st = 1;
            1: begin m_opc = b[5:0]; m_st = 2; end
            2: begin m_a = b; m_st = 3; end
            default: begin
                r = alu_fn(m_opc, m_a, b);
                exp_op.push_back({m_opc, m_a, b});
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back({5'b0, m_sticky, r[8], (r[7:0] == 8'h00)});
                m_sticky = 1'b0;
                m_st     = 0;
            end
        endcase
    endtask

    task automatic model_reset();
        m_st = 0; m_sticky = 1'b0; m_tcnt = 0;
        exp_tx.delete(); exp_op.delete();
    endtask

    // ---------------- per-cycle compare process ----------------
    int         cyc = 0;
    int         n_pops = 0;
    int         n_valid = 0;
    int         valid_cyc = 0;
    int         last_pop_cyc = 0;
    logic [7:0] tx_log[$];
    int         wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_write) begin
                tx_log.push_back(tx_data);
                wr_cyc.push_back(cyc);
                check("tx_write_while_full", {31'b0, tx_full}, 32'd0);
                if (exp_tx.size() == 0) check("tx_unexpected_write", {24'b0, tx_data}, 32'hFFFF_FFFF);
                else check("tx_byte", {24'b0, tx_data}, {24'b0, exp_tx.pop_front()});
            end else begin
                check("tx_idle_data_zero", {24'b0, tx_data}, 32'd0);
            end
            if (rx_read) begin
                check("pop_while_empty", {31'b0, rx_empty}, 32'd0);
                n_pops++;
                last_pop_cyc = cyc;
            end
            if (alu_valid) begin
                n_valid++;
                valid_cyc = cyc;
                check("busy_in_exec", {31'b0, busy}, 32'd1);
                check("exec_after_last_pop", cyc, last_pop_cyc + 1);
                check("timeout_cnt_at_exec", {24'b0, tcnt}, m_tcnt);
                if (exp_op.size() == 0) check("alu_unexpected_valid", {10'b0, alu_opc, alu_a, alu_b}, 32'hFFFF_FFFF);
                else check("alu_operands", {10'b0, alu_opc, alu_a, alu_b}, {10'b0, exp_op.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    logic rand_full = 1'b0;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_full) tx_full = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int   t;
        logic popped;
        model_byte(b, gap);
        rx_empty = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_empty = 1'b0;
        t = 0;
        do begin
            @(negedge clk); popped = rx_read;
            @(posedge clk); #1; t++;
        end while (!popped && t < 400);
        rx_empty = 1'b1;
        rx_data  = 8'h00;
        if (!popped) check("pop_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        send(8'hA5, 0); send(opc, 0); send(a, 0); send(b, 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while ((exp_tx.size() != 0 || busy) && t < 1000);
        if (t >= 1000) check("idle_wait_expired", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        tx_log.delete(); wr_cyc.delete();
    endtask

    function automatic int rgap();
        int r = $urandom_range(0, 19);
        if (r < 14) return r % 3;
        case (r)
            14: return 14;
            15: return 15;
            16, 17: return 16;
            18: return 17;
            default: return 25;
        endcase
    endfunction

    logic [7:0] opc_tab [6] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27};

    // ---------------- main sequence ----------------
    initial begin
        int p0, rel_cyc, v0;
        rst = 1'b1; rx_data = 8'hA5; rx_empty = 1'b0; tx_full = 1'b0;

        // Reset state: no strobes even with data available, all outputs zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rx_read", {31'b0, rx_read}, 0);
        check("rst_tx_write", {31'b0, tx_write}, 0);
        check("rst_outputs", {tx_data, alu_a, alu_b, 2'b0, alu_opc}, 0);
        check("rst_valid_busy", {30'b0, alu_valid, busy}, 0);
        check("rst_timeout_cnt", {24'b0, tcnt}, 0);
        @(posedge clk); #1;
        rst = 1'b0; rx_empty = 1'b1;
        model_reset();
        repeat (2) begin @(posedge clk); #1; end

        // Basic ADD frame and minimum latency.
        clear_logs(); p0 = n_pops; v0 = n_valid;
        send_frame(8'h20, 8'h05, 8'h03);
        wait_idle();
        check("f1_pops", n_pops - p0, 4);
        check("f1_valid_count", n_valid - v0, 1);
        check("f1_nwrites", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check("f1_result", tx_log[0], 8'h08);
            check("f1_status", tx_log[1], 8'h00);
            check("f1_result_latency", wr_cyc[0] - valid_cyc, 1);
            check("f1_status_latency", wr_cyc[1] - valid_cyc, 2);
        end

        // Leading junk is discarded; FF+01 gives zero and carry.
        clear_logs(); p0 = n_pops;
        send(8'h11, 0); send(8'h22, 1);
        send_frame(8'h20, 8'hFF, 8'h01);
        wait_idle();
        check("f2_pops", n_pops - p0, 6);
        check("f2_nwrites", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check("f2_result", tx_log[0], 8'h00);
            check("f2_status", tx_log[1], 8'h03);
        end

        // Timeout: 16 empty cycles after the opcode aborts the frame.
        clear_logs();
        send(8'hA5, 0); send(8'h20, 0); send(8'h05, TO);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("to_count_one", {24'b0, tcnt}, 1);
        check("to_busy_hunt", {31'b0, busy}, 0);
        check("to_no_tx", tx_log.size(), 0);
        @(posedge clk); #1;
        // One cycle short of the limit must not abort.
        send(8'hA5, 0); send(8'h20, TO - 1); send(8'h05, 0); send(8'h03, 0);
        wait_idle();
        send_frame(8'h20, 8'h05, 8'h03);
        wait_idle();
        check("to_nwrites", tx_log.size(), 4);
        if (tx_log.size() == 4) begin
            check("to_sticky_status", tx_log[1], 8'h04);
            check("to_cleared_status", tx_log[3], 8'h00);
        end
        check("to_count_after", {24'b0, tcnt}, 1);

        // TX full held for 5 cycles in TX_RES.
        clear_logs();
        tx_full = 1'b1;
        send_frame(8'h22, 8'h09, 8'h02);
        repeat (6) begin @(posedge clk); #1; end
        rel_cyc = cyc;
        tx_full = 1'b0;
        wait_idle();
        check("stall_nwrites", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check("stall_first_write_cycle", wr_cyc[0], rel_cyc);
            check("stall_result", tx_log[0], 8'h07);
            check("stall_status", tx_log[1], 8'h00);
        end

        // Reset while waiting in OPB, with a byte available.
        send(8'hA5, 0); send(8'h20, 0); send(8'h05, 0);
        @(negedge clk);
        check("mid_frame_busy", {31'b0, busy}, 1);
        @(posedge clk); #1;
        rx_data = 8'h77; rx_empty = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_no_pop", {31'b0, rx_read}, 0);
        check("rst_cycle_no_write", {31'b0, tx_write}, 0);
        @(posedge clk); #1;
        rst = 1'b0; rx_empty = 1'b1;
        model_reset();
        @(negedge clk);
        check("post_rst_operands", {8'b0, alu_a, alu_b, 2'b0, alu_opc}, 0);
        check("post_rst_flags", {22'b0, tcnt, alu_valid, busy}, 0);
        @(posedge clk); #1;
        clear_logs();
        send_frame(8'h22, 8'h09, 8'h04);
        wait_idle();
        check("post_rst_nwrites", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            check("post_rst_result", tx_log[0], 8'h05);
            check("post_rst_status", tx_log[1], 8'h00);
        end

        // Randomised frames with junk, varied gaps and random TX backpressure.
        rand_full = 1'b1;
        for (int f = 0; f < 40; f++) begin
            int nj = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) send(8'($urandom), rgap());
            send(8'hA5, rgap());
            send(opc_tab[$urandom_range(0, 5)], rgap());
            send(8'($urandom), rgap());
            send(8'($urandom), rgap());
        end
        wait_idle();
        rand_full = 1'b0;
        tx_full   = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Saturation of the aborted-frame counter.
        for (int k = 0; k < 260; k++) begin
            send(8'hA5, 0);
            send(8'h00, TO);
        end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("sat_timeout_cnt", {24'b0, tcnt}, 32'hFF);
        check("sat_model_cnt", m_tcnt, 255);
        @(posedge clk); #1;
        clear_logs();
        send_frame(8'h20, 8'h05, 8'h03);
        wait_idle();
        check("sat_nwrites", tx_log.size(), 2);
        if (tx_log.size() == 2) check("sat_status", tx_log[1], 8'h04);
        check("sat_cnt_holds", {24'b0, tcnt}, 32'hFF);

        check("leftover_tx_expect", exp_tx.size(), 0);
        check("leftover_op_expect", exp_op.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/alu_frame_interface.md
ALU_FRAME_INTERFACE -- requirements
Module: alu_frame_interface

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter NB_DATA, default 8: UART byte and ALU operand width; the block SHALL support only NB_DATA >= 8.
REQ-003 Parameter NB_OPCODE, default 6: ALU opcode width, with NB_OPCODE <= NB_DATA.
REQ-004 Parameter SYNC_BYTE, default 8'hA5: frame header value, zero-extended to NB_DATA.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000000: maximum clock cycles allowed between frame bytes; NB_TIMEOUT = clog2(TIMEOUT_CYCLES+1).
REQ-006 Port i_clk, input, 1: clock.
REQ-007 Port i_reset, input, 1: synchronous active-high reset.
REQ-008 Port i_data_to_read, input, NB_DATA: RX FIFO head word (first-word-fall-through), valid whenever i_fifo_rx_empty=0.
REQ-009 Port i_fifo_rx_empty, input, 1: RX FIFO empty.
REQ-010 Port i_fifo_tx_full, input, 1: TX FIFO full.
REQ-011 Port i_alu_result, input, NB_DATA: combinational ALU result.
REQ-012 Port i_alu_zero and i_alu_carry, input, 1 each: ALU flags.
REQ-013 Port o_fifo_rx_read, output, 1: RX pop strobe.
REQ-014 Port o_fifo_tx_write, output, 1: TX push strobe.
REQ-015 Port o_data_to_write, output, NB_DATA: TX byte.
REQ-016 Ports o_alu_opcode (NB_OPCODE), o_alu_op_A (NB_DATA), o_alu_op_B (NB_DATA), output: registered ALU operands.
REQ-017 Port o_alu_valid, output, 1: one-cycle pulse while operands are stable for sampling.
REQ-018 Port o_busy, output, 1: high in every state except HUNT.
REQ-019 Port o_timeout_cnt, output, NB_DATA: saturating count of aborted frames.

Function
REQ-020 The block SHALL implement the states HUNT, OPCODE, OPA, OPB, EXEC, TX_RES and TX_STAT.
REQ-021 In HUNT, RX_state (OPCODE/OPA/OPB) and every other state, o_fifo_rx_read SHALL be 1 only when the state is HUNT or an RX_state and i_fifo_rx_empty=0; it is combinational, and a pop consumes the head word in that cycle.
REQ-022 In HUNT, a popped word equal to SYNC_BYTE SHALL move the block to OPCODE; any other word is discarded and the block stays in HUNT.
REQ-023 A pop in OPCODE SHALL latch i_data_to_read[NB_OPCODE-1:0] into o_alu_opcode and go to OPA.
REQ-024 A pop in OPA SHALL latch o_alu_op_A and go to OPB; a pop in OPB SHALL latch o_alu_op_B and go to EXEC.
REQ-025 In EXEC, lasting exactly 1 cycle, o_alu_valid SHALL be 1 and the block SHALL register i_alu_result, i_alu_zero and i_alu_carry, then go to TX_RES.
REQ-026 In TX_RES, when i_fifo_tx_full=0, o_fifo_tx_write SHALL be 1 and o_data_to_write SHALL equal the registered result, and the block goes to TX_STAT; while full, the block holds with the write at 0.
REQ-027 In TX_STAT, the block SHALL write the status byte under the same full rule, then clear the sticky timeout flag and go to HUNT.
REQ-028 Status byte: bit0 = zero, bit1 = carry, bit2 = sticky timeout flag, all other bits 0.
REQ-029 o_data_to_write SHALL be 0 whenever o_fifo_tx_write=0.
REQ-030 The inter-byte counter SHALL clear on every pop and on entry to any RX_state, and SHALL increment each cycle an RX_state sees an empty FIFO.
REQ-031 When the counter reaches TIMEOUT_CYCLES, the block SHALL abandon the frame to HUNT, set the sticky flag, and increment o_timeout_cnt, saturating at all-ones.
REQ-032 A pop and a timeout in the same cycle: the pop SHALL win and the counter clears.
REQ-033 A byte equal to SYNC_BYTE received in OPCODE/OPA/OPB SHALL be treated as data and not as a resync.
REQ-034 Minimum frame-to-response latency with no stalls: the last pop is in cycle n, EXEC is in n+1, the result write is in n+2 and the status write is in n+3.

Reset
REQ-035 On reset, the block SHALL go to HUNT, and all registers and outputs SHALL be 0, including o_timeout_cnt, the sticky flag, the counter and the latched operands.
REQ-036 A reset asserted mid-frame or while stalled on TX full SHALL discard the frame, and no pop or write may occur during the reset cycle.

Verification
REQ-037 Frame A5,20,05,03 with ALU=ADD -> o_alu_valid 1 cycle, TX writes 08 then 00, 4 pops total.
REQ-038 Leading bytes 11,22 then A5,20,FF,01 -> 11 and 22 discarded, TX writes 00 then 03 (zero+carry).
REQ-039 With TIMEOUT_CYCLES=16: A5,20 then a 16-cycle gap -> back to HUNT, o_timeout_cnt=1, no TX; the next good frame's status has bit2=1, and the following frame's status has bit2=0.
REQ-040 TX full held for 5 cycles in TX_RES -> no write during the stall, result written in the first cycle it is not full, byte order preserved.
REQ-041 Reset asserted in OPB -> all outputs 0, a subsequent frame processed normally.
REQ-042 The 256 timeouts -> o_timeout_cnt saturates at FF.
